bp_network_deserializer: RTL and testbench

- Receive-side counterpart of the network serializer. It accepts a stream of flits, each carrying {dest_id, src_id, payload}, and reassembles num_packets_p consecutive payloads into one wide message.
- The message is presented on a valid/yumi output channel, together with the header ids latched from the first flit.
- It sits at the network egress in front of the ME consumer (cache/directory side).

---
 rtl/bp_network_deserializer_pkg.sv | 42 ++++
 rtl/bp_network_deserializer_sipo.sv | 101 ++++++++++
 rtl/bp_network_deserializer.sv | 97 +++++++++
 tb/tb_bp_network_deserializer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_network_deserializer_pkg.sv
// ============================================================================
// Module      : bp_network_pkg
// Description : Shared definitions for the network serializer/deserializer
//               pair: FSM state encodings, sizing helpers, flit struct macro.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef BP_NETWORK_FLIT_S_DEFINED
`define BP_NETWORK_FLIT_S_DEFINED
// Declares the packed flit type {dest_id, src_id, payload}, dest_id at the MSB.
`define BP_NETWORK_FLIT_S(name, dw, sw, pw) \
    typedef struct packed { \
        logic [(dw)-1:0] dest_id; \
        logic [(sw)-1:0] src_id; \
        logic [(pw)-1:0] payload; \
    } name
`endif

package bp_network_pkg;

    localparam logic [0:0] BP_ST_RECV = 1'b0;
    localparam logic [0:0] BP_ST_FULL = 1'b1;

    // Flits per message; an exact divide still costs one extra (pad) flit so
    // the count lines up with the serializer.
    function automatic int bp_num_packets(input int data_w, input int packet_w);
        return (data_w / packet_w) + 1;
    endfunction

    function automatic int bp_flit_width(input int packet_w, input int dest_w, input int src_w);
        return packet_w + dest_w + src_w;
    endfunction

    // Slot counter width, never narrower than one bit.
    function automatic int bp_cnt_width(input int num_packets);
        return (num_packets > 1) ? $clog2(num_packets) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bp_network_deserializer_sipo.sv
// ============================================================================
// Module      : bp_network_sipo
// Description : Serial-in parallel-out payload buffer. Collects num_packets_p
//               payload slots (first slot lowest order) and holds the result
//               on a valid/yumi channel until the consumer takes it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bp_network_sipo
    import bp_network_pkg::*;
#(
    parameter int packet_data_width_p = 8,
    parameter int data_width_p        = 16,
    parameter int num_packets_p       = bp_num_packets(data_width_p, packet_data_width_p)
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic                           valid_i,
    input  logic [packet_data_width_p-1:0] data_i,
    output logic                           ready_o,
    output logic                           first_o,
    output logic                           valid_o,
    output logic [data_width_p-1:0]        data_o,
    input  logic                           yumi_i
);

    localparam int                    cnt_width_lp = bp_cnt_width(num_packets_p);
    localparam logic [cnt_width_lp-1:0] c_last_cnt = cnt_width_lp'(num_packets_p - 1);
    localparam logic [cnt_width_lp-1:0] c_one      = cnt_width_lp'(1);

    logic [0:0]              state_q, state_d;
    logic [cnt_width_lp-1:0] cnt_q, cnt_d;
    logic [data_width_p-1:0] buf_q, buf_d;
    logic                    w_accept;

    assign w_accept = valid_i & ready_o;

    // Per-slot write: only the bits of a slot that land inside the message are
    // stored, so the pad bits of the last flit never reach a flop.
    for (genvar i = 0; i < num_packets_p; i++) begin : g_slot
        localparam int c_lo = i * packet_data_width_p;
        localparam int c_w  = (data_width_p - c_lo >= packet_data_width_p) ? packet_data_width_p :
                              ((data_width_p > c_lo) ? (data_width_p - c_lo) : 0);
        if (c_w > 0) begin : g_store
            assign buf_d[c_lo +: c_w] = (w_accept && (cnt_q == cnt_width_lp'(i)))
                                      ? data_i[c_w-1:0] : buf_q[c_lo +: c_w];
        end
    end

    // State register: FSM state, slot counter and payload buffer.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= BP_ST_RECV;
            cnt_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
        end
    end

    // Next state: count accepted flits, turn FULL on the last slot, back on yumi.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            BP_ST_RECV: begin
                if (w_accept) begin
                    if (cnt_q == c_last_cnt) begin
                        cnt_d   = '0;
                        state_d = BP_ST_FULL;
                    end else begin
                        cnt_d = cnt_q + c_one;
                    end
                end
            end
            BP_ST_FULL: begin
                if (yumi_i) begin
                    state_d = BP_ST_RECV;
                end
            end
            default: state_d = BP_ST_RECV;
        endcase
    end

    // Outputs depend on registered state only.
    always_comb begin
        ready_o = (state_q == BP_ST_RECV);
        valid_o = (state_q == BP_ST_FULL);
        first_o = (cnt_q == '0);
        data_o  = buf_q;
    end

    // The consumer may only take a message that is being offered.
    a_yumi_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> valid_o);

endmodule

`default_nettype wire

// File: rtl/bp_network_deserializer.sv
// ============================================================================
// Module      : bp_network_deserializer
// Description : Network egress deserializer. Reassembles num_packets_p flits
//               into one message, latches the header ids of the first flit and
//               pulses hdr_err_o when a later flit carries a different header.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bp_network_deserializer
    import bp_network_pkg::*;
#(
    parameter  int dest_id_width_p     = 4,
    parameter  int src_id_width_p      = 4,
    parameter  int source_data_width_p = 16,
    parameter  int packet_data_width_p = 8,
    localparam int num_packets_p       = bp_num_packets(source_data_width_p, packet_data_width_p),
    localparam int flit_width_lp       = bp_flit_width(packet_data_width_p, dest_id_width_p, src_id_width_p)
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic                           valid_i,
    input  logic [flit_width_lp-1:0]       data_i,
    output logic                           ready_o,
    output logic                           valid_o,
    output logic [source_data_width_p-1:0] data_o,
    output logic [dest_id_width_p-1:0]     dest_id_o,
    output logic [src_id_width_p-1:0]      src_id_o,
    input  logic                           yumi_i,
    output logic                           hdr_err_o
);

    localparam int hdr_width_lp = dest_id_width_p + src_id_width_p;

    `BP_NETWORK_FLIT_S(flit_s, dest_id_width_p, src_id_width_p, packet_data_width_p);

    flit_s                   w_flit;
    logic                    w_accept;
    logic                    w_first;
    logic [hdr_width_lp-1:0] w_flit_hdr;
    logic [hdr_width_lp-1:0] hdr_q, hdr_d;
    logic                    hdr_err_q, hdr_err_d;

    assign w_flit     = data_i;
    assign w_flit_hdr = {w_flit.dest_id, w_flit.src_id};
    assign w_accept   = valid_i & ready_o;

    bp_network_sipo #(
        .packet_data_width_p (packet_data_width_p),
        .data_width_p        (source_data_width_p),
        .num_packets_p       (num_packets_p)
    ) u_sipo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .valid_i   (valid_i),
        .data_i    (w_flit.payload),
        .ready_o   (ready_o),
        .first_o   (w_first),
        .valid_o   (valid_o),
        .data_o    (data_o),
        .yumi_i    (yumi_i)
    );

    // Header latch and one-cycle mismatch flag.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            hdr_q     <= '0;
            hdr_err_q <= 1'b0;
        end else begin
            hdr_q     <= hdr_d;
            hdr_err_q <= hdr_err_d;
        end
    end

    // Slot 0 sets the header; later slots are compared but never overwrite it.
    always_comb begin
        hdr_d     = hdr_q;
        hdr_err_d = 1'b0;
        if (w_accept) begin
            if (w_first) begin
                hdr_d = w_flit_hdr;
            end else if (w_flit_hdr != hdr_q) begin
                hdr_err_d = 1'b1;
            end
        end
    end

    // Unpack the latched header onto the id outputs.
    always_comb begin
        dest_id_o = hdr_q[hdr_width_lp-1 -: dest_id_width_p];
        src_id_o  = hdr_q[src_id_width_p-1:0];
        hdr_err_o = hdr_err_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_bp_network_deserializer.sv
// ============================================================================
// Module      : tb_bp_network_deserializer
// Description : Self-checking bench for bp_network_deserializer: default
//               configuration against a queue-based message model, plus an
//               exact-divide configuration (S=16, P=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bp_network_deserializer;

    localparam int D  = 4;
    localparam int SI = 4;
    localparam int SW = 16;
    localparam int P  = 8;
    localparam int N  = SW / P + 1;
    localparam int FW = P + D + SI;
    localparam int P2  = 4;
    localparam int FW2 = P2 + D + SI;

    logic clk = 1'b0;
    logic reset_n_i = 1'b0;
    always #5 clk = ~clk;

    // Default instance
    logic          valid_i = 1'b0;
    logic [FW-1:0] data_i  = '0;
    logic          yumi_i  = 1'b0;
    logic          ready_o, valid_o, hdr_err_o;
    logic [SW-1:0] data_o;
    logic [D-1:0]  dest_id_o;
    logic [SI-1:0] src_id_o;

    // Exact-divide instance
    logic           v2 = 1'b0;
    logic [FW2-1:0] d2 = '0;
    logic           y2 = 1'b0;
    logic           r2, vo2, he2;
    logic [SW-1:0]  do2;
    logic [D-1:0]   de2;
    logic [SI-1:0]  sr2;

    bp_network_deserializer dut (
        .clk_i     (clk),
        .reset_n_i (reset_n_i),
        .valid_i   (valid_i),
        .data_i    (data_i),
        .ready_o   (ready_o),
        .valid_o   (valid_o),
        .data_o    (data_o),
        .dest_id_o (dest_id_o),
        .src_id_o  (src_id_o),
        .yumi_i    (yumi_i),
        .hdr_err_o (hdr_err_o)
    );

    bp_network_deserializer #(
        .source_data_width_p (16),
        .packet_data_width_p (4)
    ) dut_exact (
        .clk_i     (clk),
        .reset_n_i (reset_n_i),
        .valid_i   (v2),
        .data_i    (d2),
        .ready_o   (r2),
        .valid_o   (vo2),
        .data_o    (do2),
        .dest_id_o (de2),
        .src_id_o  (sr2),
        .yumi_i    (y2),
        .hdr_err_o (he2)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit         m_full    = 1'b0;
    logic [SW-1:0] m_data = '0;
    logic [7:0] m_hdr     = '0;
    logic [7:0] m_out_hdr = '0;
    logic [P-1:0] pq[$];
    bit         exp_err   = 1'b0;
    int         delivered = 0;

    // Message = payloads placed little-end first, truncated to the message width.
    function automatic logic [SW-1:0] assemble();
        logic [N*P-1:0] t;
        t = '0;
        for (int k = 0; k < N; k++) t = t | ((N*P)'(pq[k]) << (k * P));
        return t[SW-1:0];
    endfunction

    // Called at a negedge: drive one cycle, then check at the next negedge.
    task automatic step(input bit v, input logic [FW-1:0] f, input bit y);
        bit acc;
        bit yy;
        yy      = y & m_full;
        valid_i = v;
        data_i  = f;
        yumi_i  = yy;
        acc     = v && !m_full;
        @(posedge clk);
        @(negedge clk);
        yumi_i  = 1'b0;
        exp_err = 1'b0;
        if (yy) begin
            m_full = 1'b0;
            delivered++;
        end
        if (acc) begin
            if (pq.size() == 0) m_hdr = f[FW-1 -: 8];
            else if (f[FW-1 -: 8] != m_hdr) exp_err = 1'b1;
            pq.push_back(f[P-1:0]);
            if (pq.size() == N) begin
                m_data    = assemble();
                m_out_hdr = m_hdr;
                m_full    = 1'b1;
                pq.delete();
            end
        end
        chk("valid_o", 32'(valid_o), 32'(m_full));
        chk("ready_o", 32'(ready_o), 32'(!m_full));
        chk("hdr_err_o", 32'(hdr_err_o), 32'(exp_err));
        if (m_full) begin
            chk("data_o", 32'(data_o), 32'(m_data));
            chk("dest_id_o", 32'(dest_id_o), 32'(m_out_hdr[7:4]));
            chk("src_id_o", 32'(src_id_o), 32'(m_out_hdr[3:0]));
        end
    endtask

    function automatic logic [FW-1:0] mk(input logic [3:0] d, input logic [3:0] s, input logic [7:0] p);
        return {d, s, p};
    endfunction

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic do_reset();
        valid_i = 1'b0;
        yumi_i  = 1'b0;
        #2;
        reset_n_i = 1'b0;
        #1;
        chk("rst_valid_o", 32'(valid_o), 32'd0);
        chk("rst_ready_o", 32'(ready_o), 32'd1);
        chk("rst_hdr_err_o", 32'(hdr_err_o), 32'd0);
        chk("rst_dest_id_o", 32'(dest_id_o), 32'd0);
        m_full  = 1'b0;
        exp_err = 1'b0;
        pq.delete();
        @(negedge clk);
        reset_n_i = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        logic [3:0] nib [5];
        logic [FW-1:0] f;
        logic [7:0] hdr;
        bit v, hold, accn;
        int sent, k, cyc;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("reset_valid_o", 32'(valid_o), 32'd0);
        chk("reset_ready_o", 32'(ready_o), 32'd1);
        chk("reset_hdr_err_o", 32'(hdr_err_o), 32'd0);
        chk("reset_data_o", 32'(data_o), 32'd0);
        chk("reset_dest_id_o", 32'(dest_id_o), 32'd0);
        chk("reset_src_id_o", 32'(src_id_o), 32'd0);
        reset_n_i = 1'b1;
        @(negedge clk);

        // Basic message, yumi as soon as valid_o is seen
        step(1, mk(4'h3, 4'h5, 8'hCD), 0);
        step(1, mk(4'h3, 4'h5, 8'hAB), 0);
        step(1, mk(4'h3, 4'h5, 8'h00), 0);
        chk("basic_data", 32'(data_o), 32'h0000ABCD);
        step(0, '0, 1);

        // Backpressure with a held flit
        step(1, mk(4'h3, 4'h5, 8'h11), 0);
        step(1, mk(4'h3, 4'h5, 8'h22), 0);
        step(1, mk(4'h3, 4'h5, 8'h33), 0);
        for (int i = 0; i < 10; i++) step(1, mk(4'h3, 4'h5, 8'h44), 0);
        chk("bp_data", 32'(data_o), 32'h00002211);
        step(1, mk(4'h3, 4'h5, 8'h44), 1);
        step(1, mk(4'h3, 4'h5, 8'h44), 0);
        step(1, mk(4'h3, 4'h5, 8'h55), 0);
        step(1, mk(4'h3, 4'h5, 8'h66), 0);
        chk("bp_next_data", 32'(data_o), 32'h00005544);
        step(0, '0, 1);

        // Header mismatch on the second flit
        step(1, mk(4'h3, 4'h5, 8'hCD), 0);
        step(1, mk(4'h7, 4'h5, 8'hAB), 0);
        chk("hdr_err_pulse", 32'(hdr_err_o), 32'd1);
        step(1, mk(4'h3, 4'h5, 8'h00), 0);
        chk("hdr_err_drop", 32'(hdr_err_o), 32'd0);
        chk("hdr_err_dest", 32'(dest_id_o), 32'd3);
        chk("hdr_err_data", 32'(data_o), 32'h0000ABCD);
        step(0, '0, 1);

        // Reset mid-message
        step(1, mk(4'h3, 4'h5, 8'h99), 0);
        step(1, mk(4'h3, 4'h5, 8'h88), 0);
        do_reset();
        step(1, mk(4'h3, 4'h5, 8'h11), 0);
        step(1, mk(4'h3, 4'h5, 8'h22), 0);
        step(1, mk(4'h3, 4'h5, 8'h00), 0);
        chk("rst_mid_data", 32'(data_o), 32'h00002211);

        // Reset while FULL drops the message
        do_reset();
        step(0, '0, 0);

        // Randomized gapped traffic
        delivered = 0;
        sent = 0;
        k = 0;
        cyc = 0;
        hold = 1'b0;
        v = 1'b0;
        f = '0;
        hdr = 8'($urandom);
        while (delivered < 100 && cyc < 5000) begin
            if (!hold) begin
                v = (sent < 100) && ($urandom_range(0, 1) == 1);
                if (v) f = {hdr, 8'($urandom)};
            end
            accn = v && !m_full;
            if (accn) begin
                k++;
                if (k == N) begin
                    k = 0;
                    sent++;
                    hdr = 8'($urandom);
                end
            end
            hold = v && !accn;
            step(v, f, $urandom_range(0, 1) == 1);
            cyc++;
        end
        chk("rand_delivered", 32'(delivered), 32'd100);
        valid_i = 1'b0;
        @(negedge clk);

        // Exact-divide configuration: five flits, the fifth is pure pad
        nib[0] = 4'h1; nib[1] = 4'h2; nib[2] = 4'h3; nib[3] = 4'h4; nib[4] = 4'hF;
        for (int j = 0; j < 5; j++) begin
            v2 = 1'b1;
            d2 = {4'h2, 4'h9, nib[j]};
            @(posedge clk);
            @(negedge clk);
            if (j == 3) chk("exact_not_full_at4", 32'(vo2), 32'd0);
        end
        v2 = 1'b0;
        chk("exact_valid", 32'(vo2), 32'd1);
        chk("exact_ready", 32'(r2), 32'd0);
        chk("exact_data", 32'(do2), 32'h00004321);
        chk("exact_dest", 32'(de2), 32'd2);
        chk("exact_src", 32'(sr2), 32'd9);
        chk("exact_hdr_err", 32'(he2), 32'd0);
        y2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        y2 = 1'b0;
        chk("exact_after_yumi_valid", 32'(vo2), 32'd0);
        chk("exact_after_yumi_ready", 32'(r2), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
